layer_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single layer-result memory port (`crd`/`cwr`/`csel`/`caddr_rd`/`caddr_wr`/`cdata_wr`/`cdata_rd`) among three requesters:
- requester 0: L0 conv writer
- requester 1: L1 max-pool engine
- requester 2: L2 flatten engine

It accepts at most one read or write per cycle, registers the winning command onto the memory bus and routes read data back to the issuing requester with a tag. It lets one requester lock the port for a bounded burst. It sits between the layer engines and the testbench-side layer memories.

---
 rtl/layer_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_layer_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the layer-result memory port among
// the L0 conv, L1 max-pool and L2 flatten engines, with bounded lock.
module layer_mem_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int AW       = 12,
  parameter int DW       = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [8:0]      sel,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            crd,
  output logic            cwr,
  output logic [2:0]      csel,
  output logic [AW-1:0]   caddr_rd,
  output logic [AW-1:0]   caddr_wr,
  output logic [DW-1:0]   cdata_wr,
  input  logic [DW-1:0]   cdata_rd
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [1:0]    last;
  logic          lock_pend;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    rtag;

  logic [1:0]    c0;
  logic [1:0]    c1;
  logic [1:0]    win;
  logic          any;
  logic          lock_use;

  logic [2:0]    sel_a   [3];
  logic [AW-1:0] addr_a  [3];
  logic [DW-1:0] wdata_a [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sel_a[i]   = sel[i*3 +: 3];
      addr_a[i]  = addr[i*AW +: AW];
      wdata_a[i] = wdata[i*DW +: DW];
    end
  end

  // Search order after the last winner: last+1, last+2, last (mod 3).
  always_comb begin
    c0       = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c1       = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    lock_use = lock_pend && req[last] && (lock_cnt < CW'(MAX_LOCK));
    win      = last;
    any      = 1'b0;
    if (lock_use) begin
      win = last;
      any = 1'b1;
    end else if (req[c0]) begin
      win = c0;
      any = 1'b1;
    end else if (req[c1]) begin
      win = c1;
      any = 1'b1;
    end else if (req[last]) begin
      win = last;
      any = 1'b1;
    end
    gnt = '0;
    if (any && !reset) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= 2'd2;
      lock_pend <= 1'b0;
      lock_cnt  <= '0;
    end else if (any) begin
      last      <= win;
      lock_pend <= lock[win];
      lock_cnt  <= lock_use ? lock_cnt + CW'(1) : '0;
    end else begin
      lock_pend <= 1'b0;
      lock_cnt  <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= '0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      rtag     <= '0;
    end else begin
      crd  <= any && !we[win];
      cwr  <= any && we[win];
      csel <= any ? sel_a[win] : 3'd0;
      if (any && we[win]) begin
        caddr_wr <= addr_a[win];
        cdata_wr <= wdata_a[win];
      end
      if (any && !we[win]) begin
        caddr_rd <= addr_a[win];
        rtag     <= win;
      end
    end
  end

  // Memory answers in the crd cycle; return it tagged one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (crd) begin
        rvalid[rtag] <= 1'b1;
        rdata        <= cdata_rd;
      end
    end
  end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Self-checking bench for layer_mem_arbiter against a
// rule-level arbitration and read-return model.
module tb_layer_mem_arbiter;

  localparam int ML = 4;
  localparam int AW = 12;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [2:0]    lock = '0;
  logic [8:0]    sel = '0;
  logic [35:0]   addr = '0;
  logic [59:0]   wdata = '0;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          crd;
  logic          cwr;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_rd;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd;
  logic [DW-1:0] mem [0:4095];

  assign cdata_rd = mem[caddr_rd];

  layer_mem_arbiter #(.MAX_LOCK(ML), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .sel(sel), .addr(addr), .wdata(wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .crd(crd), .cwr(cwr),
    .csel(csel), .caddr_rd(caddr_rd), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int m_last;
  int m_cnt;
  bit m_pend;
  logic          e_crd, e_cwr;
  logic [2:0]    e_csel;
  logic [AW-1:0] e_ard, e_awr;
  logic [DW-1:0] e_dwr;

  typedef struct {
    int tag;
    logic [AW-1:0] a;
    int due;
  } rd_t;
  rd_t rq[$];

  int w;
  bit bl;
  logic [2:0]    exp_gnt;
  logic [2:0]    exp_rv;
  logic [DW-1:0] exp_rd;

  function automatic int pick(input logic [2:0] r, output bit by_lock);
    by_lock = 1'b0;
    if (m_pend && r[m_last] && m_cnt < ML) begin
      by_lock = 1'b1;
      return m_last;
    end
    for (int k = 1; k <= 3; k++)
      if (r[(m_last + k) % 3]) return (m_last + k) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 2; m_pend = 0; m_cnt = 0;
    e_crd = 0; e_cwr = 0; e_csel = 0;
    e_ard = 0; e_awr = 0; e_dwr = 0;
    rq.delete();
  endtask

  task automatic sample();
    @(negedge clk);
    w = pick(req, bl);
    exp_gnt = (w < 0) ? 3'b000 : 3'(1 << w);
    exp_rv = 3'b000;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv = 3'(1 << rq[0].tag);
      exp_rd = mem[rq[0].a];
    end
  endtask

  task automatic commit();
    rd_t t;
    if (exp_rv != 0) void'(rq.pop_front());
    if (w >= 0) begin
      m_cnt  = bl ? m_cnt + 1 : 0;
      m_last = w;
      m_pend = lock[w];
      e_crd  = !we[w];
      e_cwr  = we[w];
      e_csel = sel[w*3 +: 3];
      if (we[w]) begin
        e_awr = addr[w*AW +: AW];
        e_dwr = wdata[w*DW +: DW];
      end else begin
        e_ard = addr[w*AW +: AW];
        t.tag = w; t.a = e_ard; t.due = cyc + 2;
        rq.push_back(t);
      end
    end else begin
      m_pend = 0; m_cnt = 0;
      e_crd = 0; e_cwr = 0; e_csel = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0; we = '0; lock = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req = 3'b111;
    #2;
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_gnt got=%b exp=000", gnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({rvalid, rdata, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      errors++;
      $display("FAIL reset_outs crd=%b cwr=%b csel=%0d rv=%b rd=%h exp=all0",
               crd, cwr, csel, rvalid, rdata);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    req = 3'b001; we = 3'b001; lock = '0;
    sel[2:0] = 3'd1; addr[11:0] = 12'h041; wdata[19:0] = 20'h00ABC;
    sample();
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL wr_gnt got=%b exp=001", gnt);
    end
    commit();
    req = '0;
    sample();
    checks++;
    if ({cwr, crd, csel, caddr_wr, cdata_wr} !== {1'b1, 1'b0, 3'd1, 12'h041, 20'h00ABC}) begin
      errors++;
      $display("FAIL wr_issue cwr=%b crd=%b csel=%0d a=%h d=%h exp=1 0 1 041 00abc",
               cwr, crd, csel, caddr_wr, cdata_wr);
    end
    commit();
    sample();
    checks++;
    if (cwr !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse cwr=%b exp=0", cwr);
    end
    commit();
  endtask

  task automatic test_read_return();
    req = 3'b010; we = 3'b000;
    sel[5:3] = 3'd3; addr[23:12] = 12'h005;
    sample();
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL rd_gnt got=%b exp=010", gnt);
    end
    commit();
    req = '0;
    sample();
    checks++;
    if ({crd, cwr, csel, caddr_rd} !== {1'b1, 1'b0, 3'd3, 12'h005}) begin
      errors++;
      $display("FAIL rd_issue crd=%b cwr=%b csel=%0d a=%h exp=1 0 3 005",
               crd, cwr, csel, caddr_rd);
    end
    commit();
    sample();
    checks++;
    if ({rvalid, rdata} !== {3'b010, 20'h12345}) begin
      errors++;
      $display("FAIL rd_return rv=%b rd=%h exp=010 12345", rvalid, rdata);
    end
    commit();
    sample();
    checks++;
    if (rvalid !== 3'b000) begin
      errors++;
      $display("FAIL rd_strobe rv=%b exp=000", rvalid);
    end
    commit();
  endtask

  task automatic test_round_robin();
    logic [2:0] tbl [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    req = 3'b111; we = 3'b000; lock = '0;
    for (int k = 0; k < 6; k++) begin
      sample();
      checks++;
      if (gnt !== tbl[k] || gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt step=%0d got=%b exp=%b", k, gnt, tbl[k]);
      end
      commit();
    end
    req = '0;
  endtask

  task automatic test_lock_limit();
    logic [2:0] tbl [10] = '{3'b001, 3'b100, 3'b100, 3'b100, 3'b100,
                             3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
    apply_reset();
    we = 3'b101; lock = 3'b100;
    for (int k = 0; k < 10; k++) begin
      req = (k == 8) ? 3'b001 : 3'b101;
      sample();
      checks++;
      if (gnt !== tbl[k] || gnt !== exp_gnt) begin
        errors++;
        $display("FAIL lock_gnt step=%0d got=%b exp=%b", k, gnt, tbl[k]);
      end
      commit();
    end
    req = '0; lock = '0;
    sample();
    commit();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    req = 3'b001; we = 3'b000;
    addr[11:0] = 12'h077;
    sample();
    commit();
    req = 3'b011; we = 3'b011;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs gnt=%b crd=%b rv=%b exp=all0", gnt, crd, rvalid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sample();
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL mid_first_gnt got=%b exp=001", gnt);
    end
    commit();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if (rvalid !== 3'b000) begin
        errors++;
        $display("FAIL mid_no_rvalid step=%0d rv=%b exp=000", k, rvalid);
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit pend [3];
    for (int i = 0; i < 3; i++) pend[i] = 0;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          we[i] = 1'($urandom);
          sel[i*3 +: 3] = 3'($urandom);
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*DW +: DW] = DW'($urandom);
        end
        req[i] = pend[i];
        lock[i] = ($urandom_range(0, 3) == 0);
      end
      sample();
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
      end
      checks++;
      if ({crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !==
          {e_crd, e_cwr, e_csel, e_ard, e_awr, e_dwr}) begin
        errors++;
        $display("FAIL rnd_issue cyc=%0d got=%b%b %0d %h %h %h exp=%b%b %0d %h %h %h",
                 cyc, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr,
                 e_crd, e_cwr, e_csel, e_ard, e_awr, e_dwr);
      end
      checks++;
      if (rvalid !== exp_rv || (exp_rv != 0 && rdata !== exp_rd)) begin
        errors++;
        $display("FAIL rnd_return cyc=%0d rv=%b rd=%h exp=%b %h",
                 cyc, rvalid, rdata, exp_rv, exp_rd);
      end
      if (w >= 0) pend[w] = 0;
      commit();
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    mem[5] = 20'h12345;
    model_reset();
    test_reset();
    test_single_write();
    test_read_return();
    test_round_robin();
    test_lock_limit();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
